// File: rtl/mc_datapath_p_if.sv
// Bus/control bundle between the external control FSM, the MIO bus and mc_datapath_p.
// The master modport is the FSM/bus side; the slave modport is the datapath.
interface mc_datapath_p_if;
    localparam int unsigned DW = 32;

    logic            MIO_ready;
    logic            IorD;
    logic            IRWrite;
    logic [1:0]      RegDst;
    logic            RegWrite;
    logic [1:0]      MemtoReg;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic            ExtSel;
    logic [1:0]      PCSource;
    logic            PCWrite;
    logic            PCWriteCond;
    logic            Branch;
    logic [2:0]      ALU_operation;
    logic [DW-1:0]   data2CPU;

    logic            zero;
    logic            overflow;
    logic [DW-1:0]   PC_Current;
    logic [DW-1:0]   Inst;
    logic [DW-1:0]   data_out;
    logic [DW-1:0]   M_addr;
    logic            trap;
    logic [DW-1:0]   EPC;

    modport master (
        output MIO_ready, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
               ExtSel, PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, data2CPU,
        input  zero, overflow, PC_Current, Inst, data_out, M_addr, trap, EPC
    );

    modport slave (
        input  MIO_ready, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
               ExtSel, PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, data2CPU,
        output zero, overflow, PC_Current, Inst, data_out, M_addr, trap, EPC
    );
endinterface

// File: rtl/mc_datapath_p.sv
// Parametrised multi-cycle MIPS datapath with operand latches, MIO stall and
// selectable immediate extension. Optional overflow trap: define MDP_OVF_TRAP_EN.
module mc_datapath_p #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0180,
    parameter int unsigned RF_AW    = 5
) (
    input  logic           clk,
    input  logic           reset,
    mc_datapath_p_if.slave bus
);
    localparam int unsigned DW   = 32;
    localparam int unsigned RF_N = 32'(1) << RF_AW;

    logic [DW-1:0]    pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d, aluout_q, aluout_d;
    logic [DW-1:0]    rf_q [RF_N];
    logic [RF_AW-1:0] rs, rt, rd, rf_wa;
    logic [DW-1:0]    rd_a, rd_b, rf_wd, ext_imm, src_a, src_b, res;
    logic             rf_we, ovf_c, zero_c, pc_en;

    // Register-file read ports and immediate extension
    always_comb begin
        rs      = ir_q[21 +: RF_AW];
        rt      = ir_q[16 +: RF_AW];
        rd      = ir_q[11 +: RF_AW];
        rd_a    = (rs == '0) ? '0 : rf_q[rs];
        rd_b    = (rt == '0) ? '0 : rf_q[rt];
        ext_imm = bus.ExtSel ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0000, ir_q[15:0]};
    end

    // ALU operand muxes, result and signed overflow
    always_comb begin
        res   = '0;
        ovf_c = 1'b0;
        src_a = bus.ALUSrcA ? a_q : pc_q;
        case (bus.ALUSrcB)
            2'd0:    src_b = b_q;
            2'd1:    src_b = 32'd4;
            2'd2:    src_b = ext_imm;
            default: src_b = {ext_imm[DW-3:0], 2'b00};
        endcase
        case (bus.ALU_operation)
            3'b000: res = src_a & src_b;
            3'b001: res = src_a | src_b;
            3'b010: begin
                res   = src_a + src_b;
                ovf_c = (src_a[DW-1] == src_b[DW-1]) & (res[DW-1] != src_a[DW-1]);
            end
            3'b110: begin
                res   = src_a - src_b;
                ovf_c = (src_a[DW-1] == ~src_b[DW-1]) & (res[DW-1] != src_a[DW-1]);
            end
            3'b111:  res = {31'b0, ($signed(src_a) < $signed(src_b))};
            3'b100:  res = ~(src_a | src_b);
            3'b101:  res = src_b >> src_a[4:0];
            default: res = src_a ^ src_b;
        endcase
        zero_c = (res == '0);
    end

`ifdef MDP_OVF_TRAP_EN
    logic          ovf_q, ovf_d, trap_q, trap_d, trap_take;
    logic [DW-1:0] epc_q, epc_d;
`else
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

    // Next-state for PC, IR, operand latches, ALUOut, MDR and RF write port
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        rf_we    = 1'b0;
        case (bus.RegDst)
            2'd0:    rf_wa = rt;
            2'd1:    rf_wa = rd;
            2'd2:    rf_wa = '1;
            default: rf_wa = '0;
        endcase
        case (bus.MemtoReg)
            2'd0:    rf_wd = aluout_q;
            2'd1:    rf_wd = mdr_q;
            2'd2:    rf_wd = {ir_q[15:0], 16'h0000};
            default: rf_wd = res;
        endcase
        pc_en = bus.MIO_ready & (bus.PCWrite | (bus.PCWriteCond & (zero_c == bus.Branch)));
        if (bus.MIO_ready) begin
            a_d      = rd_a;
            b_d      = rd_b;
            aluout_d = res;
            mdr_d    = bus.data2CPU;
            if (bus.IRWrite) ir_d = bus.data2CPU;
            rf_we    = bus.RegWrite & (rf_wa != '0);
        end
        if (pc_en) begin
            case (bus.PCSource)
                2'd0:    pc_d = res;
                2'd1:    pc_d = aluout_q;
                2'd2:    pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                default: pc_d = a_q;
            endcase
        end
`ifdef MDP_OVF_TRAP_EN
        ovf_d     = bus.MIO_ready ? ovf_c : ovf_q;
        epc_d     = epc_q;
        trap_take = bus.RegWrite & (bus.MemtoReg == 2'd0) & bus.MIO_ready & ovf_q;
        trap_d    = trap_take;
        if (trap_take) begin
            rf_we = 1'b0;
            pc_d  = TRAP_VEC;
            epc_d = pc_q - 32'd4;
        end
`endif
    end

    // Datapath state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    // Register file: synchronous write, r0 never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RF_N; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

`ifdef MDP_OVF_TRAP_EN
    // Overflow latch, exception PC and trap pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q  <= 1'b0;
            epc_q  <= '0;
            trap_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            epc_q  <= epc_d;
            trap_q <= trap_d;
        end
    end
    assign bus.trap = trap_q;
    assign bus.EPC  = epc_q;
`else
    assign bus.trap = 1'b0;
    assign bus.EPC  = '0;
`endif

    assign bus.zero       = zero_c;
    assign bus.overflow   = ovf_c;
    assign bus.PC_Current = pc_q;
    assign bus.Inst       = ir_q;
    assign bus.data_out   = b_q;
    assign bus.M_addr     = bus.IorD ? aluout_q : pc_q;
endmodule

// File: tb/tb_mc_datapath_p.sv
// Directed bench for mc_datapath_p with an expected-value queue.
module tb_mc_datapath_p;
    logic clk;
    logic reset;
    mc_datapath_p_if bus ();

    mc_datapath_p #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: observed %h with no expected value queued", obs);
        end else begin
            e = sb.pop_front();
            n_chk++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.MIO_ready     = 1'b1;
        bus.IorD          = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegDst        = 2'd0;
        bus.RegWrite      = 1'b0;
        bus.MemtoReg      = 2'd0;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = 2'd0;
        bus.ExtSel        = 1'b0;
        bus.PCSource      = 2'd0;
        bus.PCWrite       = 1'b0;
        bus.PCWriteCond   = 1'b0;
        bus.Branch        = 1'b0;
        bus.ALU_operation = 3'b000;
    endtask

    task automatic load_ir(input logic [31:0] inst);
        bus.data2CPU = inst;
        bus.IRWrite  = 1'b1;
        tick();
        bus.IRWrite  = 1'b0;
    endtask

    // Puts RF[r] onto data_out through the B latch
    task automatic read_reg(input logic [4:0] r);
        load_ir(rtype(5'd0, r, 5'd0, 6'h20));
        tick();
    endtask

    task automatic exec_i(input logic [31:0] inst, input logic [2:0] op, input logic ext);
        load_ir(inst);
        tick();
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'd2; bus.ExtSel = ext; bus.ALU_operation = op;
        tick();
        idle();
        bus.RegWrite = 1'b1; bus.RegDst = 2'd0; bus.MemtoReg = 2'd0;
        tick();
        idle();
    endtask

    // Fetch + operand + execute of an R-type; leaves write-back to the caller
    task automatic exec_r_ex(input logic [31:0] inst, input logic [2:0] op, output logic ovf);
        load_ir(inst);
        tick();
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'd0; bus.ALU_operation = op;
        #1;
        ovf = bus.overflow;
        tick();
        idle();
        bus.RegWrite = 1'b1; bus.RegDst = 2'd1; bus.MemtoReg = 2'd0;
    endtask

    task automatic branch(input logic [31:0] inst, input logic br, input logic chk_addr);
        load_ir(inst);
        tick();
        bus.ALUSrcA = 1'b0; bus.ALUSrcB = 2'd3; bus.ExtSel = 1'b1; bus.ALU_operation = OP_ADD;
        tick();
        idle();
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'd0; bus.ALU_operation = OP_SUB;
        bus.PCWriteCond = 1'b1; bus.Branch = br; bus.PCSource = 2'd1; bus.IorD = 1'b1;
        #1;
        check({31'b0, bus.zero});
        if (chk_addr) check(bus.M_addr);
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ovf;
        logic [31:0] lui5;
        reset        = 1'b0;
        bus.data2CPU = 32'h0;
        idle();
        tick();
        tick();

        push_exp("reset_pc", 32'h0000_0100);   check(bus.PC_Current);
        push_exp("reset_ir", 32'h0);           check(bus.Inst);
        push_exp("reset_maddr", 32'h0000_0100); check(bus.M_addr);
        push_exp("reset_trap", 32'h0);         check({31'b0, bus.trap});
        push_exp("reset_epc", 32'h0);          check(bus.EPC);
        reset = 1'b1;
        tick();
        push_exp("reset_r31", 32'h0); read_reg(5'd31); check(bus.data_out);
        push_exp("reset_r1", 32'h0);  read_reg(5'd1);  check(bus.data_out);

        // addi r1,r0,-1 sign-extended, then add r2,r1,r1
        exec_i(itype(6'h08, 5'd0, 5'd1, 16'hFFFF), OP_ADD, 1'b1);
        push_exp("add_ovf", 32'h0);
        exec_r_ex(rtype(5'd1, 5'd1, 5'd2, 6'h20), OP_ADD, ovf);
        check({31'b0, ovf});
        tick();
        idle();
        push_exp("add_r2", 32'hFFFF_FFFE); read_reg(5'd2); check(bus.data_out);
        exec_i(itype(6'h08, 5'd0, 5'd1, 16'hFFFF), OP_ADD, 1'b0);
        push_exp("zext_r1", 32'h0000_FFFF); read_reg(5'd1); check(bus.data_out);

        // beq taken / bne not taken on equal operands
        exec_i(itype(6'h08, 5'd0, 5'd3, 16'd5), OP_ADD, 1'b1);
        exec_i(itype(6'h08, 5'd0, 5'd4, 16'd5), OP_ADD, 1'b1);
        push_exp("beq_zero", 32'h1);
        branch(itype(6'h04, 5'd3, 5'd4, 16'h0010), 1'b1, 1'b0);
        push_exp("beq_pc", 32'h0000_0140); check(bus.PC_Current);
        push_exp("bne_zero", 32'h1);
        push_exp("bne_maddr", 32'h0000_0180);
        branch(itype(6'h05, 5'd3, 5'd4, 16'h0010), 1'b0, 1'b1);
        push_exp("bne_pc", 32'h0000_0140); check(bus.PC_Current);

        // Stall: all writes requested but MIO_ready low
        lui5 = itype(6'h0f, 5'd0, 5'd5, 16'h1234);
        load_ir(lui5);
        bus.MIO_ready = 1'b0; bus.PCWrite = 1'b1; bus.PCSource = 2'd0;
        bus.ALUSrcA = 1'b0; bus.ALUSrcB = 2'd1; bus.ALU_operation = OP_ADD;
        bus.IRWrite = 1'b1; bus.data2CPU = 32'hAAAA_5555;
        bus.RegWrite = 1'b1; bus.RegDst = 2'd0; bus.MemtoReg = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_exp("stall_pc", 32'h0000_0140); check(bus.PC_Current);
            push_exp("stall_ir", lui5);          check(bus.Inst);
        end
        bus.MIO_ready = 1'b1;
        tick();
        idle();
        push_exp("release_pc", 32'h0000_0144); check(bus.PC_Current);
        push_exp("release_ir", 32'hAAAA_5555); check(bus.Inst);
        push_exp("release_r5", 32'h1234_0000); read_reg(5'd5); check(bus.data_out);

        // 0x7FFF_FFFF + 1
        load_ir(itype(6'h0f, 5'd0, 5'd6, 16'h7FFF));
        bus.RegWrite = 1'b1; bus.RegDst = 2'd0; bus.MemtoReg = 2'd2;
        tick();
        idle();
        exec_i(itype(6'h0d, 5'd6, 5'd6, 16'hFFFF), OP_OR, 1'b0);
        exec_i(itype(6'h08, 5'd0, 5'd7, 16'd1), OP_ADD, 1'b1);
        push_exp("max_ovf", 32'h1);
        exec_r_ex(rtype(5'd6, 5'd7, 5'd8, 6'h20), OP_ADD, ovf);
        check({31'b0, ovf});
        tick();
        idle();
`ifdef MDP_OVF_TRAP_EN
        push_exp("trap_pulse", 32'h1);       check({31'b0, bus.trap});
        push_exp("trap_pc", 32'h0000_0180);  check(bus.PC_Current);
        push_exp("trap_epc", 32'h0000_0140); check(bus.EPC);
        tick();
        push_exp("trap_end", 32'h0);         check({31'b0, bus.trap});
        push_exp("trap_r8", 32'h0); read_reg(5'd8); check(bus.data_out);
`else
        push_exp("notrap", 32'h0);           check({31'b0, bus.trap});
        push_exp("wrap_r8", 32'h8000_0000); read_reg(5'd8); check(bus.data_out);
`endif

        // r0 stays zero
        bus.data2CPU = 32'hDEAD_BEEF;
        tick();
        bus.RegWrite = 1'b1; bus.RegDst = 2'd3; bus.MemtoReg = 2'd1;
        tick();
        bus.RegDst = 2'd1;
        tick();
        idle();
        push_exp("r0_zero", 32'h0); read_reg(5'd0); check(bus.data_out);

        // Reset in the middle of a write-back
        load_ir(itype(6'h23, 5'd0, 5'd9, 16'h0));
        bus.data2CPU = 32'h1234_5678;
        tick();
        bus.RegWrite = 1'b1; bus.RegDst = 2'd0; bus.MemtoReg = 2'd1;
        #2;
        reset = 1'b0;
        #1;
        push_exp("async_pc", 32'h0000_0100); check(bus.PC_Current);
        push_exp("async_ir", 32'h0);         check(bus.Inst);
        tick();
        idle();
        reset = 1'b1;
        push_exp("abort_r9", 32'h0); read_reg(5'd9); check(bus.data_out);
        push_exp("abort_r5", 32'h0); read_reg(5'd5); check(bus.data_out);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: observed %0d leftover entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
